// File: rtl/level_scroll_renderer.sv
// Scrolling level-map pixel generator: world offset updated once per frame,
// two-stage pipeline (world-x translate, then colour lookup) with lava glow.
module level_scroll_renderer #(
    parameter int                         WORLD_W     = 1024,
    parameter int                         GROUND_Y    = 380,
    parameter int                         GRASS_H     = 20,
    parameter int                         NUM_PITS    = 3,
    parameter logic [10*NUM_PITS-1:0]     PIT_LO      = {10'd520, 10'd350, 10'd100},
    parameter logic [10*NUM_PITS-1:0]     PIT_HI      = {10'd600, 10'd450, 10'd200},
    parameter int                         NUM_PLATS   = 2,
    parameter logic [10*NUM_PLATS-1:0]    PLAT_LO     = {10'd450, 10'd250},
    parameter logic [10*NUM_PLATS-1:0]    PLAT_HI     = {10'd530, 10'd330},
    parameter logic [10*NUM_PLATS-1:0]    PLAT_Y      = {10'd300, 10'd250},
    parameter int                         GLOW_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active_pixels,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        scroll_en,
    input  logic        scroll_dir,
    input  logic [2:0]  speed,
    output logic [9:0]  scroll_x,
    output logic [23:0] rgb,
    output logic        rgb_active
);

    localparam logic [9:0]  WRAP_MASK = 10'(WORLD_W - 1);
    localparam logic [9:0]  GRASS_TOP = 10'(GROUND_Y);
    localparam logic [9:0]  DIRT_TOP  = 10'(GROUND_Y + GRASS_H);
    localparam int          FW        = (GLOW_FRAMES > 1) ? $clog2(GLOW_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(GLOW_FRAMES - 1);

    localparam logic [23:0] SKY    = 24'h87CEEB;
    localparam logic [23:0] GRASS  = 24'h228B22;
    localparam logic [23:0] DIRT   = 24'h8B4513;
    localparam logic [23:0] LAVA   = 24'hFF4500;
    localparam logic [23:0] GLOW_0 = 24'hFF8C00;
    localparam logic [23:0] GLOW_1 = 24'hFFD700;
    localparam logic [23:0] PLAT   = 24'hA0522D;

    logic [9:0]    scroll_next;
    logic [FW-1:0] frame_cnt;
    logic          glow_phase;

    logic [9:0]    wx_s1;
    logic [9:0]    y_s1;
    logic          act_s1;

    logic          in_pit;
    logic          in_plat;
    logic          grass_row;
    logic          dirt_row;
    logic [23:0]   colour;

    // Masking after the add/subtract gives the modulo-WORLD_W wrap both ways
    always_comb begin
        if (scroll_dir)
            scroll_next = (scroll_x - {7'd0, speed}) & WRAP_MASK;
        else
            scroll_next = (scroll_x + {7'd0, speed}) & WRAP_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            scroll_x <= 10'd0;
        else if (frame_tick && scroll_en)
            scroll_x <= scroll_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt  <= '0;
            glow_phase <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt  <= '0;
                glow_phase <= ~glow_phase;
            end else begin
                frame_cnt  <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wx_s1  <= 10'd0;
            y_s1   <= 10'd0;
            act_s1 <= 1'b0;
        end else begin
            wx_s1  <= (x + scroll_x) & WRAP_MASK;
            y_s1   <= y;
            act_s1 <= active_pixels;
        end
    end

    always_comb begin
        in_pit  = 1'b0;
        in_plat = 1'b0;
        for (int i = 0; i < NUM_PITS; i++) begin
            if (wx_s1 >= PIT_LO[i*10 +: 10] && wx_s1 <= PIT_HI[i*10 +: 10])
                in_pit = 1'b1;
        end
        for (int i = 0; i < NUM_PLATS; i++) begin
            if (wx_s1 >= PLAT_LO[i*10 +: 10] && wx_s1 <= PLAT_HI[i*10 +: 10] &&
                y_s1 >= PLAT_Y[i*10 +: 10] && y_s1 <= PLAT_Y[i*10 +: 10] + 10'd10)
                in_plat = 1'b1;
        end
    end

    // Later assignments win, so this reads bottom-up as highest priority
    always_comb begin
        grass_row = (y_s1 >= GRASS_TOP) && (y_s1 < DIRT_TOP);
        dirt_row  = (y_s1 >= DIRT_TOP);
        colour    = SKY;
        if (grass_row)
            colour = GRASS;
        if (dirt_row)
            colour = DIRT;
        if (in_pit && dirt_row)
            colour = LAVA;
        if (in_pit && grass_row)
            colour = glow_phase ? GLOW_1 : GLOW_0;
        if (in_plat)
            colour = PLAT;
        if (!act_s1)
            colour = 24'h000000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb        <= 24'h000000;
            rgb_active <= 1'b0;
        end else begin
            rgb        <= colour;
            rgb_active <= act_s1;
        end
    end

endmodule
